// File: rtl/unidade_controle_jogo_pkg.sv
// Shared definitions for the memory-game control unit: state codes (also used
// by the datapath hex decoder and the top-level bench) and the output bundle.
package unidade_controle_jogo_pkg;

    localparam int ESTADO_W = 4;

    // State codes are fixed so the 7-segment debug display reads them directly.
    typedef enum logic [ESTADO_W-1:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    // Control and status lines decoded from the state register.
    typedef struct packed {
        logic zera_c;
        logic conta_c;
        logic zera_r;
        logic registra_r;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } saidas_t;

    localparam saidas_t SAIDAS_NULAS = '0;

    // True for the three states that end a game.
    function automatic logic eh_final(input estado_t e);
        return (e == FIM_ACERTO) || (e == FIM_ERRO) || (e == FIM_TIMEOUT);
    endfunction

endpackage

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// Per-play timeout counter: cleared by zera, counts up while conta is high,
// saturates at M-1 and flags fim there.
module contador_timeout #(
    parameter int M  = 150_000_000,
    parameter int TW = $clog2(M)
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam logic [TW-1:0] ULTIMO = TW'(M - 1);

    logic [TW-1:0] r_contagem;

    // Count register: clear has priority, hold at the last value instead of wrapping.
    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_contagem <= '0;
        end else if (zera) begin
            r_contagem <= '0;
        end else if (conta && (r_contagem != ULTIMO)) begin
            r_contagem <= r_contagem + TW'(1);
        end
    end

    assign fim = (r_contagem == ULTIMO);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the memory game: sequences ROM address counter, key
// register and comparator, and ends the game on error, success or timeout.
module unidade_controle_jogo
    import unidade_controle_jogo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 150_000_000,
    parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim_contagem,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t r_estado;
    estado_t w_proximo;
    saidas_t w_saidas;
    logic    w_fim_timeout;
    logic    w_em_espera;

    assign w_em_espera = (r_estado == ESPERA);

    // The timer is held cleared outside ESPERA, so every play gets a full window.
    contador_timeout #(
        .M  (TIMEOUT_CYCLES),
        .TW (TW)
    ) u_contador_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (!w_em_espera),
        .conta (w_em_espera),
        .fim   (w_fim_timeout)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // Next-state logic and Moore output decode from the current state only.
    // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latches).
    always_comb begin
        w_proximo = r_estado;
        w_saidas  = SAIDAS_NULAS;
        case (r_estado)
            INICIAL: begin
                if (iniciar) w_proximo = PREPARA;
            end
            PREPARA: begin
                w_saidas.zera_c = 1'b1;
                w_saidas.zera_r = 1'b1;
                w_proximo       = ESPERA;
            end
            ESPERA: begin
                // A key press in the last allowed cycle still counts as a play.
                if (jogada)             w_proximo = REGISTRA;
                else if (w_fim_timeout) w_proximo = FIM_TIMEOUT;
            end
            REGISTRA: begin
                w_saidas.registra_r = 1'b1;
                w_proximo           = COMPARA;
            end
            COMPARA: begin
                if (!igual)            w_proximo = FIM_ERRO;
                else if (fim_contagem) w_proximo = FIM_ACERTO;
                else                   w_proximo = PROXIMO;
            end
            PROXIMO: begin
                w_saidas.conta_c = 1'b1;
                w_proximo        = ESPERA;
            end
            FIM_ACERTO: begin
                w_saidas.pronto  = 1'b1;
                w_saidas.acertou = 1'b1;
            end
            FIM_ERRO: begin
                w_saidas.pronto = 1'b1;
                w_saidas.errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                w_saidas.pronto  = 1'b1;
                w_saidas.errou   = 1'b1;
                w_saidas.timeout = 1'b1;
            end
            default: begin
                w_proximo = INICIAL;
            end
        endcase
        // Any final state restarts on iniciar.
        if (eh_final(r_estado) && iniciar) w_proximo = PREPARA;
    end

    assign zeraC     = w_saidas.zera_c;
    assign contaC    = w_saidas.conta_c;
    assign zeraR     = w_saidas.zera_r;
    assign registraR = w_saidas.registra_r;
    assign pronto    = w_saidas.pronto;
    assign acertou   = w_saidas.acertou;
    assign errou     = w_saidas.errou;
    assign timeout   = w_saidas.timeout;
    assign db_estado = r_estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Self-checking bench for unidade_controle_jogo with an 8-cycle timeout.
module tb_unidade_controle_jogo;
    import unidade_controle_jogo_pkg::*;

    localparam int TO = 8;

    // Expected output vectors {zeraC,contaC,zeraR,registraR,pronto,acertou,errou,timeout}.
    localparam logic [7:0] O_NADA    = 8'b0000_0000;
    localparam logic [7:0] O_ZERA    = 8'b1010_0000;
    localparam logic [7:0] O_CONTA   = 8'b0100_0000;
    localparam logic [7:0] O_REG     = 8'b0001_0000;
    localparam logic [7:0] O_ACERTO  = 8'b0000_1100;
    localparam logic [7:0] O_ERRO    = 8'b0000_1010;
    localparam logic [7:0] O_TIMEOUT = 8'b0000_1011;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fim_contagem;
    logic       zeraC, contaC, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;
    logic [7:0] saidas;

    assign saidas = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};

    unidade_controle_jogo #(.TIMEOUT_CYCLES(TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .jogada       (jogada),
        .igual        (igual),
        .fim_contagem (fim_contagem),
        .zeraC        (zeraC),
        .contaC       (contaC),
        .zeraR        (zeraR),
        .registraR    (registraR),
        .pronto       (pronto),
        .acertou      (acertou),
        .errou        (errou),
        .timeout      (timeout),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       iniciar;
        logic       jogada;
        logic       igual;
        logic       fim;
        logic [3:0] estado;
        logic [7:0] saidas;
    } vetor_t;

    vetor_t tabela[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     n_zerac, n_contac, n_reg;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    // One clock edge, then settle; counts output pulses seen in the new cycle.
    task automatic step();
        @(posedge clock);
        #1;
        if (zeraC)     n_zerac++;
        if (contaC)    n_contac++;
        if (registraR) n_reg++;
    endtask

    task automatic zera_contadores();
        n_zerac  = 0;
        n_contac = 0;
        n_reg    = 0;
    endtask

    task automatic aplica_reset();
        iniciar = 0; jogada = 0; igual = 0; fim_contagem = 0;
        reset = 1'b0;
        #12;
        reset = 1'b1;
        step();
    endtask

    task automatic add(input logic ini, input logic jog, input logic ig, input logic fc,
                       input estado_t e, input logic [7:0] o);
        vetor_t v;
        v.iniciar = ini; v.jogada = jog; v.igual = ig; v.fim = fc;
        v.estado = e; v.saidas = o;
        tabela.push_back(v);
    endtask

    // One play from ESPERA: pulse jogada, present comparator result, take decision.
    task automatic joga(input logic ig, input logic fc, input estado_t esperado);
        jogada = 1;
        step();
        jogada = 0;
        igual = ig; fim_contagem = fc;
        step();
        step();
        check("decisao", 32'(db_estado), 32'(esperado));
        igual = 0; fim_contagem = 0;
    endtask

    task automatic inicia_jogo();
        iniciar = 1;
        step();
        iniciar = 0;
        step();
        check("inicio_espera", 32'(db_estado), 32'(ESPERA));
    endtask

    int n_espera;

    initial begin
        // Reset state, checked before any edge completes.
        iniciar = 0; jogada = 0; igual = 0; fim_contagem = 0;
        reset = 1'b0;
        #2;
        check("reset_estado", 32'(db_estado), 32'(INICIAL));
        check("reset_saidas", 32'(saidas), 32'(O_NADA));
        #10;
        reset = 1'b1;

        // Directed table: start, ignored iniciar/jogada, one good play, mismatch, restart.
        add(0, 0, 0, 0, INICIAL,  O_NADA);
        add(1, 0, 0, 0, PREPARA,  O_ZERA);
        add(0, 0, 0, 0, ESPERA,   O_NADA);
        add(1, 0, 0, 0, ESPERA,   O_NADA);
        add(0, 1, 0, 0, REGISTRA, O_REG);
        add(1, 1, 1, 0, COMPARA,  O_NADA);
        add(0, 0, 1, 0, PROXIMO,  O_CONTA);
        add(0, 0, 0, 0, ESPERA,   O_NADA);
        add(0, 1, 0, 0, REGISTRA, O_REG);
        add(0, 0, 0, 0, COMPARA,  O_NADA);
        add(0, 0, 0, 1, FIM_ERRO, O_ERRO);
        add(0, 0, 0, 0, FIM_ERRO, O_ERRO);
        add(0, 1, 1, 0, FIM_ERRO, O_ERRO);
        add(1, 0, 0, 0, PREPARA,  O_ZERA);
        add(0, 0, 0, 0, ESPERA,   O_NADA);
        for (int i = 0; i < tabela.size(); i++) begin
            iniciar = tabela[i].iniciar;
            jogada = tabela[i].jogada;
            igual = tabela[i].igual;
            fim_contagem = tabela[i].fim;
            step();
            check($sformatf("tab%0d_estado", i), 32'(db_estado), 32'(tabela[i].estado));
            check($sformatf("tab%0d_saidas", i), 32'(saidas), 32'(tabela[i].saidas));
        end

        // Full success: 16 correct plays, fim_contagem only on the last.
        aplica_reset();
        zera_contadores();
        inicia_jogo();
        for (int p = 0; p < 16; p++) begin
            joga(1'b1, p == 15, (p == 15) ? FIM_ACERTO : PROXIMO);
            if (p != 15) begin
                step();
                check("sucesso_volta_espera", 32'(db_estado), 32'(ESPERA));
            end
        end
        check("sucesso_zerac", 32'(n_zerac), 32'd1);
        check("sucesso_registra", 32'(n_reg), 32'd16);
        check("sucesso_conta", 32'(n_contac), 32'd15);
        check("sucesso_saidas", 32'(saidas), 32'(O_ACERTO));

        // Mismatch on the third play, restarted from FIM_ACERTO.
        zera_contadores();
        inicia_jogo();
        joga(1'b1, 1'b0, PROXIMO); step();
        joga(1'b1, 1'b0, PROXIMO); step();
        joga(1'b0, 1'b0, FIM_ERRO);
        check("erro_conta", 32'(n_contac), 32'd2);
        check("erro_registra", 32'(n_reg), 32'd3);
        check("erro_saidas", 32'(saidas), 32'(O_ERRO));

        // Timeout: count cycles spent in ESPERA with no jogada.
        inicia_jogo();
        n_espera = 1;
        for (int k = 0; k < 4 * TO; k++) begin
            step();
            if (db_estado == ESPERA) n_espera++;
            else break;
        end
        check("timeout_ciclos", 32'(n_espera), 32'(TO));
        check("timeout_estado", 32'(db_estado), 32'(FIM_TIMEOUT));
        check("timeout_saidas", 32'(saidas), 32'(O_TIMEOUT));

        // Restart from FIM_TIMEOUT: final outputs drop, zeraC pulses once.
        zera_contadores();
        iniciar = 1;
        step();
        iniciar = 0;
        check("reinicio_estado", 32'(db_estado), 32'(PREPARA));
        check("reinicio_saidas", 32'(saidas), 32'(O_ZERA));
        step();
        check("reinicio_espera", 32'(db_estado), 32'(ESPERA));
        check("reinicio_zerac", 32'(n_zerac), 32'd1);

        // jogada in the last ESPERA cycle beats the timeout.
        for (int k = 0; k < TO - 1; k++) step();
        check("limite_ainda_espera", 32'(db_estado), 32'(ESPERA));
        jogada = 1;
        step();
        jogada = 0;
        check("limite_registra", 32'(db_estado), 32'(REGISTRA));
        check("limite_sem_timeout", 32'(timeout), 32'd0);

        // Asynchronous reset mid-game while in COMPARA.
        step();
        check("pre_reset_compara", 32'(db_estado), 32'(COMPARA));
        #2;
        reset = 1'b0;
        #1;
        check("reset_async_estado", 32'(db_estado), 32'(INICIAL));
        check("reset_async_saidas", 32'(saidas), 32'(O_NADA));
        step();
        reset = 1'b1;
        step();
        step();
        check("pos_reset_estado", 32'(db_estado), 32'(INICIAL));
        check("pos_reset_saidas", 32'(saidas), 32'(O_NADA));
        iniciar = 1;
        step();
        iniciar = 0;
        check("pos_reset_prepara", 32'(db_estado), 32'(PREPARA));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
